// File: rtl/bias_pkg.sv
// rtl/bias_pkg.sv - shared state encodings and size defaults for the bias preload path
package bias_pkg;

  typedef enum logic [1:0] {
    PIDLE = 2'd0,
    PRECV = 2'd1,
    PDONE = 2'd2
  } preload_state_e;

  localparam int BRAM_DATA_WIDTH_DEF = 32;
  localparam int AXIS_FIFO_SIZE_DEF  = 16;
  localparam int CH_CNT_W            = 12;

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - first-word-fall-through register FIFO with occupancy count
module sync_fifo_fwft #(
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop_req,
  output logic [DW-1:0] rdata,
  output logic [AW:0]   cnt,
  output logic          full,
  output logic          empty,
  output logic          underflow
);

  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full      = (cnt_q == FULL_CNT);
  assign empty     = (cnt_q == '0);
  assign do_push   = push && !full && !flush;
  assign do_pop    = pop_req && !empty && !flush;
  assign underflow = pop_req && empty;
  assign rdata     = mem_q[rd_ptr_q];
  assign cnt       = cnt_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/bias_preload_fifo.sv
// rtl/bias_preload_fifo.sv - per-layer bias preload receiver feeding the bias BRAM write path
// BIAS_PRELOAD_TLAST_CHECK_EN enables the sticky TLAST position check.
module bias_preload_fifo
  import bias_pkg::*;
#(
  parameter int BRAM_DATA_WIDTH = BRAM_DATA_WIDTH_DEF,
  parameter int AXIS_FIFO_SIZE  = AXIS_FIFO_SIZE_DEF,
  parameter int BIT_NUM         = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BRAM_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  input  logic                       transfer_start,
  input  logic                       write_en,
  input  logic                       flush,
  input  logic [CH_CNT_W-1:0]        output_channel_size,
  input  logic                       fifo_read,
  output logic [BRAM_DATA_WIDTH-1:0] bias_data,
  output logic [BIT_NUM:0]           fifo_cnt,
  output logic                       fifo_not_empty,
  output logic                       preload_done,
  output logic                       rd_underflow,
  output logic                       tlast_err
);

  preload_state_e      state_q, state_d;
  logic [CH_CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic                rd_underflow_q, rd_underflow_d;
  logic [CH_CNT_W:0]   rx_cnt_inc;
  logic                fifo_full, fifo_empty, fifo_underflow;
  logic                push, size_nz;

  sync_fifo_fwft #(
    .DW    (BRAM_DATA_WIDTH),
    .DEPTH (AXIS_FIFO_SIZE),
    .AW    (BIT_NUM)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .wdata     (s_axis_tdata),
    .pop_req   (fifo_read),
    .rdata     (bias_data),
    .cnt       (fifo_cnt),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .underflow (fifo_underflow)
  );

  assign s_axis_tready  = (state_q == PRECV) && !fifo_full && !flush;
  assign push           = s_axis_tvalid && s_axis_tready;
  assign rx_cnt_inc     = {1'b0, rx_cnt_q} + (CH_CNT_W+1)'(1);
  assign size_nz        = (output_channel_size != '0);
  assign preload_done   = (rx_cnt_q >= output_channel_size) && size_nz;
  assign fifo_not_empty = !fifo_empty;
  assign rd_underflow   = rd_underflow_q;

  always_comb begin
    state_d        = state_q;
    rx_cnt_d       = rx_cnt_q;
    rd_underflow_d = rd_underflow_q;
    if (flush) begin
      state_d        = PIDLE;
      rx_cnt_d       = '0;
      rd_underflow_d = 1'b0;
    end else begin
      if (fifo_underflow) begin
        rd_underflow_d = 1'b1;
      end
      if (push) begin
        rx_cnt_d = rx_cnt_inc[CH_CNT_W-1:0];
      end
      // Leaving PRECV on the final accepted beat drops tready right after it.
      case (state_q)
        PIDLE: begin
          if (transfer_start && write_en) begin
            state_d  = PRECV;
            rx_cnt_d = '0;
          end
        end
        PRECV: begin
          if (push && size_nz && (rx_cnt_inc >= {1'b0, output_channel_size})) begin
            state_d = PDONE;
          end
        end
        PDONE:   state_d = PDONE;
        default: state_d = PIDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= PIDLE;
      rx_cnt_q       <= '0;
      rd_underflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rx_cnt_q       <= rx_cnt_d;
      rd_underflow_q <= rd_underflow_d;
    end
  end

`ifdef BIAS_PRELOAD_TLAST_CHECK_EN
  logic tlast_err_q, tlast_err_d;
  logic tlast_expected;

  assign tlast_expected = (rx_cnt_q == (output_channel_size - CH_CNT_W'(1)));
  assign tlast_err      = tlast_err_q;

  always_comb begin
    tlast_err_d = tlast_err_q;
    if (flush) begin
      tlast_err_d = 1'b0;
    end else if (push && (s_axis_tlast != tlast_expected)) begin
      tlast_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tlast_err_q <= 1'b0;
    end else begin
      tlast_err_q <= tlast_err_d;
    end
  end
`else
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
  assign tlast_err    = 1'b0;
`endif

endmodule

// File: tb/tb_bias_preload_fifo.sv
// tb/tb_bias_preload_fifo.sv - randomized bench for bias_preload_fifo against a queue model
module tb_bias_preload_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int BN    = 4;
`ifdef BIAS_PRELOAD_TLAST_CHECK_EN
  localparam bit TL_EN = 1'b1;
`else
  localparam bit TL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic          transfer_start, write_en, flush, fifo_read;
  logic [11:0]   output_channel_size;
  logic [DW-1:0] bias_data;
  logic [BN:0]   fifo_cnt;
  logic          fifo_not_empty, preload_done, rd_underflow, tlast_err;

  always #5 clk = ~clk;

  bias_preload_fifo #(
    .BRAM_DATA_WIDTH (DW),
    .AXIS_FIFO_SIZE  (DEPTH),
    .BIT_NUM         (BN)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .s_axis_tdata        (s_axis_tdata),
    .s_axis_tvalid       (s_axis_tvalid),
    .s_axis_tlast        (s_axis_tlast),
    .s_axis_tready       (s_axis_tready),
    .transfer_start      (transfer_start),
    .write_en            (write_en),
    .flush               (flush),
    .output_channel_size (output_channel_size),
    .fifo_read           (fifo_read),
    .bias_data           (bias_data),
    .fifo_cnt            (fifo_cnt),
    .fifo_not_empty      (fifo_not_empty),
    .preload_done        (preload_done),
    .rd_underflow        (rd_underflow),
    .tlast_err           (tlast_err)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] mq[$];
  bit          m_recv, m_done, m_und, m_terr;
  int          m_rx;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_recv = 0; m_done = 0; m_und = 0; m_terr = 0; m_rx = 0;
  endtask

  function automatic bit exp_tready();
    return m_recv && (mq.size() < DEPTH) && !flush;
  endfunction

  task automatic compare();
    chk("s_axis_tready", s_axis_tready, exp_tready());
    chk("fifo_cnt", fifo_cnt, mq.size());
    chk("fifo_not_empty", fifo_not_empty, mq.size() != 0);
    if (mq.size() != 0) chk("bias_data", bias_data, mq[0]);
    chk("preload_done", preload_done, (m_rx >= int'(output_channel_size)) && (output_channel_size != 0));
    chk("rd_underflow", rd_underflow, m_und);
    chk("tlast_err", tlast_err, TL_EN && m_terr);
  endtask

  task automatic model_update();
    bit tr, pushed;
    tr     = exp_tready();
    pushed = s_axis_tvalid && tr;
    if (flush) begin
      model_clear();
      return;
    end
    if (fifo_read && mq.size() == 0) m_und = 1;
    if (fifo_read && mq.size() != 0) void'(mq.pop_front());
    if (pushed) begin
      mq.push_back(s_axis_tdata);
      if (s_axis_tlast != (((m_rx + 1) % 4096) == int'(output_channel_size))) m_terr = 1;
      m_rx = (m_rx + 1) % 4096;
      if (output_channel_size != 0 && m_rx >= int'(output_channel_size)) begin
        m_recv = 0;
        m_done = 1;
      end
    end else if (!m_recv && !m_done && transfer_start && write_en) begin
      m_recv = 1;
      m_rx   = 0;
    end
  endtask

  // One clock: inputs already driven at posedge+1, checked mid-cycle, model advanced.
  task automatic step();
    if (rst) model_clear();
    #4;
    compare();
    if (!rst) model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s_axis_tdata = '0; s_axis_tvalid = 0; s_axis_tlast = 0;
    transfer_start = 0; write_en = 0; flush = 0; fifo_read = 0;
  endtask

  task automatic start_layer(input int size);
    output_channel_size = 12'(size);
    transfer_start = 1; write_en = 1;
    step();
    transfer_start = 0; write_en = 0;
  endtask

  task automatic do_flush();
    s_axis_tvalid = 0; fifo_read = 0; flush = 1;
    step();
    flush = 0;
  endtask

  task automatic push_beats(input int n, input int size, input int tlast_at);
    s_axis_tvalid = 1;
    for (int i = 0; i < n; i++) begin
      s_axis_tdata = $urandom;
      s_axis_tlast = (i == tlast_at);
      step();
    end
    s_axis_tvalid = 0; s_axis_tlast = 0;
  endtask

  initial begin
    logic [31:0] exp_ord [3];
    int          tr_cycles;
    exp_ord = '{32'hA, 32'hB, 32'hC};

    rst = 1;
    idle_inputs();
    output_channel_size = 12'd4;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_tready", s_axis_tready, 0);
    chk("reset_fifo_cnt", fifo_cnt, 0);
    chk("reset_not_empty", fifo_not_empty, 0);
    chk("reset_preload_done", preload_done, 0);
    chk("reset_rd_underflow", rd_underflow, 0);
    chk("reset_tlast_err", tlast_err, 0);
    chk("reset_bias_data", bias_data, 0);
    rst = 0;
    model_clear();

    // Basic receive: exactly four beats accepted, fifth refused.
    start_layer(4);
    tr_cycles = 0;
    s_axis_tvalid = 1;
    for (int i = 0; i < 5; i++) begin
      s_axis_tdata = $urandom;
      s_axis_tlast = (i == 3);
      if (s_axis_tready) tr_cycles++;
      step();
    end
    s_axis_tvalid = 0; s_axis_tlast = 0;
    chk("basic_tready_cycles", tr_cycles, 4);
    chk("basic_fifo_cnt", fifo_cnt, 4);
    chk("basic_preload_done", preload_done, 1);
    chk("basic_tready_after", s_axis_tready, 0);
    do_flush();

    // Backpressure at full depth.
    start_layer(20);
    push_beats(18, 20, -1);
    chk("bp_fifo_cnt_full", fifo_cnt, 16);
    chk("bp_tready_full", s_axis_tready, 0);
    s_axis_tvalid = 1; fifo_read = 1;
    step();
    fifo_read = 0;
    chk("bp_fifo_cnt_after_pop", fifo_cnt, 15);
    chk("bp_tready_after_pop", s_axis_tready, 1);
    s_axis_tvalid = 0;
    do_flush();

    // Order and first-word-fall-through.
    start_layer(3);
    s_axis_tvalid = 1;
    for (int i = 0; i < 3; i++) begin
      s_axis_tdata = exp_ord[i];
      s_axis_tlast = (i == 2);
      step();
    end
    s_axis_tvalid = 0; s_axis_tlast = 0;
    for (int i = 0; i < 3; i++) begin
      chk("order_bias_data", bias_data, exp_ord[i]);
      fifo_read = 1;
      step();
    end
    fifo_read = 0;
    chk("order_fifo_cnt_end", fifo_cnt, 0);
    do_flush();

    // Simultaneous push and pop at count 5, then underflow.
    start_layer(10);
    push_beats(5, 10, -1);
    s_axis_tvalid = 1; fifo_read = 1;
    for (int i = 0; i < 3; i++) begin
      s_axis_tdata = $urandom;
      step();
    end
    s_axis_tvalid = 0; fifo_read = 0;
    chk("pushpop_fifo_cnt", fifo_cnt, 5);
    do_flush();
    fifo_read = 1;
    step();
    fifo_read = 0;
    chk("underflow_flag", rd_underflow, 1);
    chk("underflow_fifo_cnt", fifo_cnt, 0);
    do_flush();

    // Flush mid-transfer, then start without write_en.
    start_layer(12);
    push_beats(7, 12, -1);
    chk("flush_pre_cnt", fifo_cnt, 7);
    s_axis_tvalid = 1; flush = 1;
    step();
    flush = 0;
    chk("flush_fifo_cnt", fifo_cnt, 0);
    chk("flush_tready", s_axis_tready, 0);
    transfer_start = 1; write_en = 0;
    step();
    transfer_start = 0;
    step();
    chk("start_no_we_tready", s_axis_tready, 0);
    s_axis_tvalid = 0;

    // TLAST position.
    start_layer(4);
    push_beats(4, 4, 2);
    chk("tlast_early_err", tlast_err, TL_EN);
    do_flush();
    start_layer(4);
    push_beats(4, 4, 3);
    chk("tlast_ok_err", tlast_err, 0);
    do_flush();

    // Randomized traffic, including zero-size layers, flushes and async resets.
    for (int c = 0; c < 3000; c++) begin
      if (!m_recv && !m_done) begin
        if ($urandom_range(0, 3) == 0) output_channel_size = 12'($urandom_range(0, 24));
        transfer_start = ($urandom_range(0, 3) == 0);
        write_en       = ($urandom_range(0, 3) != 0);
      end else begin
        transfer_start = ($urandom_range(0, 15) == 0);
        write_en       = $urandom_range(0, 1);
      end
      s_axis_tvalid = ($urandom_range(0, 3) != 0);
      s_axis_tdata  = $urandom;
      s_axis_tlast  = ($urandom_range(0, 9) == 0) ? 1'($urandom_range(0, 1))
                                                 : (((m_rx + 1) % 4096) == int'(output_channel_size));
      fifo_read     = ($urandom_range(0, 2) == 0);
      flush         = m_done ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 79) == 0);
      rst           = ($urandom_range(0, 699) == 0);
      step();
      rst = 0;
    end
    idle_inputs();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
